// File: rtl/spm_pkg.sv
// Shared types and defaults for the serial-parallel multiplier sequencer.
package spm_pkg;
    localparam int SPM_WIDTH  = 8;
    localparam int SPM_PROD_W = 2 * SPM_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spm_state_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction
endpackage

// File: rtl/start_debounce.sv
// Start qualifier: emits a one-cycle start_pulse on an accepted rising edge.
// SPM_SEQ_DEBOUNCE_EN requires DB_CYCLES consecutive high cycles; otherwise one high cycle after a low suffices.
module start_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic start_pulse
);
`ifdef SPM_SEQ_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    // A threshold of one degenerates to plain rising-edge detection.
    localparam int DB_EFF = DB_EN ? DB_CYCLES : 1;
    localparam int DW     = $clog2(DB_EFF + 1);

    logic [DW-1:0] hi_cnt;

    // Saturating count of consecutive high cycles; saturation blocks re-fire while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hi_cnt <= '0;
        else if (!start)
            hi_cnt <= '0;
        else if (hi_cnt != DW'(DB_EFF))
            hi_cnt <= hi_cnt + 1'b1;
    end

    assign start_pulse = start && (hi_cnt == DW'(DB_EFF - 1));
endmodule

// File: rtl/spm_seq.sv
// Sequencer for a serial-parallel multiplier array: latches operands, streams the
// sign-extended multiplier LSB first and collects the 2*WIDTH-bit product serially.
module spm_seq
    import spm_pkg::*;
#(
    parameter int WIDTH     = SPM_WIDTH,
    parameter int DB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 p_bit,
    output logic [WIDTH-1:0]     a_par,
    output logic                 x_bit,
    output logic                 spm_clr,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW = prod_width(WIDTH);
    localparam int CW = $clog2(PW);
    localparam int IW = $clog2(WIDTH);

    spm_state_t     state, state_next;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] b_reg;
    logic           start_pulse;

    start_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pulse (start_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_par   <= '0;
            b_reg   <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    a_par   <= a_in;
                    b_reg   <= b_in;
                    cnt     <= '0;
                    product <= '0;
                end
                SHIFT: begin
                    product <= {p_bit, product[PW-1:1]};
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state, so reset clears them immediately.
    always_comb begin
        state_next = state;
        x_bit      = 1'b0;
        spm_clr    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start_pulse) state_next = LOAD;
            LOAD: begin
                spm_clr    = 1'b1;
                busy       = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                busy  = 1'b1;
                x_bit = (cnt < CW'(WIDTH)) ? b_reg[cnt[IW-1:0]] : b_reg[WIDTH-1];
                if (cnt == CW'(PW - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spm_seq.sv
// Directed bench for spm_seq with a behavioural SPM array model driving p_bit.
module tb_spm_seq;
    localparam int W  = 8;
    localparam int PW = 16;
`ifdef SPM_SEQ_DEBOUNCE_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 1;
`endif
    localparam int EXP_LAT = 2 * W + 2 + HOLD - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          p_bit;
    logic [W-1:0]  a_par;
    logic          x_bit, spm_clr, busy, done;
    logic [PW-1:0] product;

    spm_seq #(.WIDTH(W), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .p_bit(p_bit), .a_par(a_par), .x_bit(x_bit), .spm_clr(spm_clr),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int xerr = 0;

    // Behavioural array: p_bit is bit k of the full signed product during SHIFT.
    logic [PW-1:0] model_prod = '0;
    logic [W-1:0]  model_b = '0;
    logic [4:0]    k = '0;
    always @(posedge clk) begin
        if (spm_clr) k <= '0;
        else if (busy) k <= k + 1'b1;
    end
    assign p_bit = model_prod[k[3:0]];

    always @(negedge clk) begin
        if (busy && !spm_clr) begin
            if (x_bit !== ((k < W) ? model_b[k[2:0]] : model_b[W-1])) xerr++;
        end else if (x_bit !== 1'b0) xerr++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_model(input logic [W-1:0] a, input logic [W-1:0] b);
        model_prod = PW'($signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}));
        model_b = b;
        a_in = a;
        b_in = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_par"}, 32'(a_par), 0);
        check({tag, "_product"}, 32'(product), 0);
        check({tag, "_ctrl"}, {28'd0, x_bit, spm_clr, busy, done}, 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [PW-1:0] exp_p, input string tag);
        int lat, clr_n, busy_n;
        bit seen;
        lat = 0; clr_n = 0; busy_n = 0; seen = 0; xerr = 0;
        set_model(a, b);
        start = 1'b1;
        while (lat < 60 && !seen) begin
            tick();
            lat++;
            if (lat >= HOLD) start = 1'b0;
            if (spm_clr) clr_n++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        check({tag, "_latency"}, lat, EXP_LAT);
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        check({tag, "_clr_cycles"}, clr_n, 1);
        check({tag, "_busy_cycles"}, busy_n, 2 * W + 1);
        check({tag, "_a_par"}, 32'(a_par), 32'(a));
        tick();
        check({tag, "_done_1cyc"}, {30'd0, done, busy}, 0);
        check({tag, "_hold"}, 32'(product), 32'(exp_p));
        check({tag, "_x_bit"}, xerr, 0);
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] p;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'd3,   8'd5,   16'h000F};
        vecs[1] = '{8'hFD,  8'd5,   16'hFFF1};
        vecs[2] = '{8'h80,  8'h80,  16'h4000};
        vecs[3] = '{8'd2,   8'hFF,  16'hFFFE};
        vecs[4] = '{8'h7F,  8'h7F,  16'h3F01};
        vecs[5] = '{8'd0,   8'h55,  16'h0000};
        vecs[6] = '{8'hFF,  8'hFF,  16'h0001};

        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
            repeat (2) tick();
        end

        // start held high for 60 cycles yields a single operation
        begin
            int dn;
            dn = 0;
            set_model(8'd3, 8'd5);
            start = 1'b1;
            repeat (60) begin tick(); if (done) dn++; end
            start = 1'b0;
            repeat (25) begin tick(); if (done) dn++; end
            check("held_done_count", dn, 1);
            check("held_product", 32'(product), 32'h000F);
        end

        // fresh edge during SHIFT is dropped, not queued
        begin
            int dn;
            dn = 0;
            set_model(8'hFD, 8'd5);
            start = 1'b1;
            for (int c = 1; c <= 50; c++) begin
                tick();
                if (c == HOLD) start = 1'b0;
                if (c == 6) start = 1'b1;
                if (c == 6 + HOLD) start = 1'b0;
                if (done) dn++;
            end
            check("reedge_done_count", dn, 1);
            check("reedge_product", 32'(product), 32'hFFF1);
        end

        // reset while SHIFT cnt = 7
        begin
            int dn;
            dn = 0;
            set_model(8'd3, 8'd5);
            start = 1'b1;
            for (int c = 1; c <= HOLD + 8; c++) begin
                tick();
                if (c >= HOLD) start = 1'b0;
            end
            check("pre_reset_k", 32'(k), 7);
            #2 rst_n = 1'b0;
            #1 check_zero("midreset");
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (25) begin tick(); if (done) dn++; end
            check("midreset_no_done", dn, 0);
            run_op(8'd2, 8'hFF, 16'hFFFE, "post_reset");
        end

`ifdef SPM_SEQ_DEBOUNCE_EN
        begin
            int bz;
            int dn;
            bz = 0;
            set_model(8'd3, 8'd5);
            start = 1'b1;
            repeat (2) tick();
            start = 1'b0;
            repeat (10) begin tick(); if (busy) bz++; end
            check("glitch_no_busy", bz, 0);
            bz = 0;
            dn = 0;
            start = 1'b1;
            repeat (4) tick();
            start = 1'b0;
            repeat (3) begin tick(); if (busy) bz++; end
            check("db4_busy", 32'(bz > 0), 1);
            repeat (30) begin tick(); if (done) dn++; end
            check("db4_done", dn, 1);
            check("db4_product", 32'(product), 32'h000F);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spm_seq.md
SPM_SEQ -- requirements
Module: spm_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 The block SHALL have parameter DB_CYCLES, default 4, the number of consecutive high cycles start must hold before it is accepted.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: already-synchronized start request level.
REQ-006 The block SHALL have port a_in, input, WIDTH bits: signed multiplicand.
REQ-007 The block SHALL have port b_in, input, WIDTH bits: signed multiplier.
REQ-008 The block SHALL have port p_bit, input, 1 bit: serial product bit from the SPM array, LSB first.
REQ-009 The block SHALL have port a_par, output, WIDTH bits: latched multiplicand driven to the SPM array.
REQ-010 The block SHALL have port x_bit, output, 1 bit: serial multiplier bit to the SPM array.
REQ-011 The block SHALL have port spm_clr, output, 1 bit: one-cycle clear of the SPM carry/sum flops.
REQ-012 The block SHALL have port busy, output, 1 bit: high from LOAD through SHIFT.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when product is valid.
REQ-014 The block SHALL have port product, output, 2*WIDTH bits: signed result, held until the next LOAD.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-016 In IDLE, an accepted start rising edge SHALL move the FSM to LOAD on the next clock.
REQ-017 LOAD SHALL last 1 cycle: it latches a_in into a_par and b_in into b_reg, asserts spm_clr, clears cnt and product, then enters SHIFT.
REQ-018 SHIFT SHALL last exactly 2*WIDTH cycles, with cnt running 0..2*WIDTH-1.
REQ-019 During SHIFT, x_bit SHALL be b_reg[cnt] for cnt < WIDTH, and b_reg[WIDTH-1] (sign extension) for cnt >= WIDTH.
REQ-020 On each SHIFT clock edge, p_bit SHALL be sampled: product <= {p_bit, product[2*WIDTH-1:1]}.
REQ-021 After the edge where cnt = 2*WIDTH-1, the FSM SHALL enter DONE; done is high for exactly that one cycle, then the FSM returns to IDLE.
REQ-022 Latency from the accepted start edge to done high SHALL be 2*WIDTH+2 cycles, i.e. 18 for WIDTH=8.
REQ-023 A start edge while busy or in DONE SHALL be ignored and not queued.
REQ-024 start held high continuously SHALL produce exactly one operation; a new operation requires start to go low, then high again.
REQ-025 Outside SHIFT, x_bit SHALL be 0; spm_clr SHALL be high only in LOAD.
REQ-026 product SHALL change only in LOAD and SHIFT, so it holds its last value in IDLE and DONE.

Reset
REQ-027 When rst_n is low, all state SHALL clear immediately and asynchronously: FSM = IDLE, cnt = 0, and a_par, b_reg, product, x_bit, spm_clr, busy, done = 0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-029 After reset release, the first start edge SHALL be accepted normally.
REQ-030 Debounce/edge history SHALL reset to "start was low".

Configuration
REQ-031 With macro SPM_SEQ_DEBOUNCE_EN defined, a start rising edge SHALL be accepted only after start is high for DB_CYCLES consecutive cycles; shorter pulses are discarded.
REQ-032 Without SPM_SEQ_DEBOUNCE_EN, a single-cycle high following a low cycle SHALL be accepted, and the LOAD timing is then counted from that cycle.

Structure
REQ-033 Package spm_pkg SHALL hold the default WIDTH, the state enum type, and the product width constant 2*WIDTH.
REQ-034 Debounce and edge detection SHALL live in sub-module start_debounce, which outputs a one-cycle start_pulse.
REQ-035 The FSM, counter and shift registers SHALL live in spm_seq.

Verification
The bench models the SPM array behaviourally: p_bit = bit cnt of a_par*sext(b) in the same cycle.
REQ-036 a_in=3, b_in=5, start pulse -> done after 18 cycles, product=0x000F.
REQ-037 a_in=-3 (0xFD), b_in=5 -> product=0xFFF1; also a_in=-128, b_in=-128 -> product=0x4000.
REQ-038 start held high 60 cycles -> exactly one done pulse; a second start edge during SHIFT -> still one done pulse.
REQ-039 rst_n low at SHIFT cnt=7 -> all outputs 0 the same cycle, no done; next start with a_in=2, b_in=-1 -> product=0xFFFE.
REQ-040 With SPM_SEQ_DEBOUNCE_EN and DB_CYCLES=4: a 2-cycle start glitch -> no busy; a 4-cycle high -> busy asserts.
